// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay-timer scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 3;

  // Index width that stays legal for any requester count.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_sched_if.sv
// Requester-side bundle of the scheduler: request/delay in, grant/done/status out.
interface delay_sched_if
  import delay_sched_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt;

  modport master (output req, delay, input grant, done, busy, cnt);
  modport slave  (input req, delay, output grant, done, busy, cnt);
endinterface

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import delay_sched_pkg::*;
#(
  parameter int  N  = DEF_N,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);

  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  always_comb begin
    o_onehot   = '0;
    o_index    = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    // Offsets 1..N visit last+1 first and last itself at the very end.
    for (int k = 1; k <= N; k++) begin
      w_cand     = (int'(i_last) + k) % N;
      w_cand_idx = IW'(w_cand);
      if (!o_valid && i_req[w_cand_idx]) begin
        o_valid              = 1'b1;
        o_index              = w_cand_idx;
        o_onehot[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Shared down-counter scheduler: grants one requester, counts its delay, pulses done.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int  N  = DEF_N,
  parameter int  W  = DEF_W,
  localparam int IW = idx_w(N)
) (
  input  logic         clk,
  input  logic         nrst,
  delay_sched_if.slave bus
);

  sched_state_t  r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [N-1:0]  r_done, w_done_nxt;
  logic [W-1:0]  r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_last, w_last_nxt;

  logic [N-1:0]  w_pick_onehot;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_valid;
  logic [W-1:0]  w_dly [N];

  for (genvar i = 0; i < N; i++) begin : g_dly
    assign w_dly[i] = bus.delay[i*W +: W];
  end

  rr_pick #(.N(N)) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_cnt   <= '0;
      r_last  <= IW'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
        if (w_pick_valid) begin
          w_state_nxt = COUNT;
          w_grant_nxt = w_pick_onehot;
          w_cnt_nxt   = w_dly[w_pick_idx];
          w_last_nxt  = w_pick_idx;
        end
      end
      COUNT: begin
        // Owner dropping its request abandons the job without a done pulse.
        if ((bus.req & r_grant) == '0) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_grant;
        end else begin
          w_cnt_nxt = r_cnt - W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.cnt   = r_cnt;
  assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: cycle-by-cycle vector table plus reset corner sequences.
module tb_delay_sched;

  logic clk;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  delay_sched_if #(.N(4), .W(3)) bus ();

  delay_sched #(.N(4), .W(3)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] dly;
    logic [3:0]  g;
    logic [3:0]  d;
    logic [2:0]  c;
    logic        b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] req, input logic [11:0] dly,
                              input logic [3:0] g, input logic [3:0] d, input logic [2:0] c,
                              input logic b);
    vec_t v;
    v.rst = rst; v.req = req; v.dly = dly; v.g = g; v.d = d; v.c = c; v.b = b;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    bus.req   = '0;
    bus.delay = '0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, " grant"}, 32'(bus.grant), 32'h0);
    chk({name, " done"},  32'(bus.done),  32'h0);
    chk({name, " cnt"},   32'(bus.cnt),   32'h0);
    chk({name, " busy"},  32'(bus.busy),  32'h0);
  endtask

  // Structural properties checked every cycle, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(bus.grant) || !$onehot0(bus.done) || ((bus.done & ~bus.grant) != 4'h0) ||
        (bus.busy !== (bus.grant != 4'h0))) begin
      failures++;
      $display("FAIL invariant: grant=%b done=%b busy=%b", bus.grant, bus.done, bus.busy);
    end
  end

  initial begin
    logic [3:0] oh;
    nrst      = 1'b0;
    bus.req   = 4'b1111;
    bus.delay = 12'h249;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("hold_reset%0d", i));
    end

    // Single request, delay 3, then zero delay on requester 2.
    add(1, 4'b0001, 12'h003, 4'b0001, 4'b0000, 3'd3, 1);
    add(0, 4'b0001, 12'h003, 4'b0001, 4'b0000, 3'd2, 1);
    add(0, 4'b0001, 12'h003, 4'b0001, 4'b0000, 3'd1, 1);
    add(0, 4'b0001, 12'h003, 4'b0001, 4'b0000, 3'd0, 1);
    add(0, 4'b0001, 12'h003, 4'b0001, 4'b0001, 3'd0, 1);
    add(0, 4'b0000, 12'h003, 4'b0000, 4'b0000, 3'd0, 0);
    add(0, 4'b0100, 12'h000, 4'b0100, 4'b0000, 3'd0, 1);
    add(0, 4'b0100, 12'h000, 4'b0100, 4'b0100, 3'd0, 1);
    add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 3'd0, 0);

    // Round-robin with everyone requesting, all delays 1.
    for (int j = 0; j < 4; j++) begin
      oh = 4'b0001 << j;
      add(j == 0, 4'b1111, 12'h249, oh, 4'b0000, 3'd1, 1);
      add(0, 4'b1111, 12'h249, oh, 4'b0000, 3'd0, 1);
      add(0, 4'b1111, 12'h249, oh, oh, 3'd0, 1);
      add(0, 4'b1111, 12'h249, 4'b0000, 4'b0000, 3'd0, 0);
    end
    add(0, 4'b1111, 12'h249, 4'b0001, 4'b0000, 3'd1, 1);

    // Abort of requester 1 at cnt=2, requester 3 pending.
    add(1, 4'b1010, 12'h028, 4'b0010, 4'b0000, 3'd5, 1);
    add(0, 4'b1010, 12'h028, 4'b0010, 4'b0000, 3'd4, 1);
    add(0, 4'b1010, 12'h028, 4'b0010, 4'b0000, 3'd3, 1);
    add(0, 4'b1010, 12'h028, 4'b0010, 4'b0000, 3'd2, 1);
    add(0, 4'b1000, 12'h428, 4'b0000, 4'b0000, 3'd0, 0);
    add(0, 4'b1000, 12'h428, 4'b1000, 4'b0000, 3'd2, 1);
    add(0, 4'b1000, 12'h428, 4'b1000, 4'b0000, 3'd1, 1);
    add(0, 4'b1000, 12'h428, 4'b1000, 4'b0000, 3'd0, 1);
    add(0, 4'b1000, 12'h428, 4'b1000, 4'b1000, 3'd0, 1);
    add(0, 4'b0000, 12'h428, 4'b0000, 4'b0000, 3'd0, 0);

    // Maximum delay loaded, then delay input changed mid-count.
    add(1, 4'b0001, 12'h007, 4'b0001, 4'b0000, 3'd7, 1);
    for (int c = 6; c >= 0; c--) add(0, 4'b0001, 12'h001, 4'b0001, 4'b0000, 3'(c), 1);
    add(0, 4'b0001, 12'h001, 4'b0001, 4'b0001, 3'd0, 1);
    add(0, 4'b0000, 12'h001, 4'b0000, 4'b0000, 3'd0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      bus.req   = vecs[i].req;
      bus.delay = vecs[i].dly;
      tick();
      chk($sformatf("row%0d grant", i), 32'(bus.grant), 32'(vecs[i].g));
      chk($sformatf("row%0d done", i),  32'(bus.done),  32'(vecs[i].d));
      chk($sformatf("row%0d cnt", i),   32'(bus.cnt),   32'(vecs[i].c));
      chk($sformatf("row%0d busy", i),  32'(bus.busy),  32'(vecs[i].b));
    end

    // Asynchronous reset in the middle of a count.
    do_reset();
    bus.req   = 4'b0001;
    bus.delay = 12'h005;
    tick();
    tick();
    chk("pre_async cnt", 32'(bus.cnt), 32'd4);
    #1 nrst = 1'b0;
    #1 chk_idle("async_reset");
    tick();
    nrst    = 1'b1;
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("post_async%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Shared delay-timer scheduler: N requesters each ask for a programmable wait of `delay` clock cycles.
- Grants a single down-counter to one requester at a time, using round-robin order.
- Loads the counter from the winner's delay, counts it down, then pulses that requester's `done`.
- Sits in front of the loadable synchronous counter datapath and sequences its load/enable.

Parameters:
N, 4, number of requesters (N >= 2)
W, 3, delay/counter width in bits

Ports:
clk  input  1  system clock, all state on rising edge
nrst  input  1  asynchronous active-low reset
req  input  N  per-requester request level; must be held until done
delay  input  N*W  packed delays; requester i uses bits [i*W +: W]
grant  output  N  one-hot (or zero) owner of the counter, registered
done  output  N  one-cycle completion pulse to the owner, registered
busy  output  1  high whenever state != IDLE
cnt  output  W  current counter value, registered

Behaviour:
- Clock and reset: one clock `clk`; reset `nrst` is asynchronous and active-low.
- Reset values:
  - While nrst=0, regardless of clk: state=IDLE, grant=0, done=0, cnt=0, busy=0.
  - Round-robin pointer last=N-1, so requester 0 has first priority after reset.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0, pick g = the first set req bit searching from last+1 upward, wrapping modulo N.
  - Next edge: grant=onehot(g), cnt=delay[g], last=g, state=COUNT.
  - If req == 0: stay in IDLE with all outputs 0.
- COUNT:
  - If req[g]=0 (abort): next edge state=IDLE, grant=0, cnt=0, no done pulse; last keeps g.
  - Else if cnt==0: next edge state=DONE, done=onehot(g); grant stays asserted.
  - Else: cnt decrements by 1, no wrap.
- DONE:
  - Lasts exactly one cycle, then state=IDLE, grant=0, done=0.
  - The done pulse is issued even if req[g] drops during DONE.
- Latency:
  - grant rises 1 cycle after req is sampled in IDLE.
  - done is high on the (delay+1)th cycle after grant rises.
  - One mandatory IDLE cycle separates jobs, so job period = delay+3 cycles.
- Delay sampling: delay is sampled only on the IDLE->COUNT edge; later changes to delay[g] have no effect on the running job.
- Non-owner requesters: req of non-owners is ignored outside IDLE; they remain pending.
- Reset mid-operation: the job is discarded immediately (async); no done is issued.
- Width rules:
  - delay=0 is legal: done comes one cycle after grant.
  - delay=2^W-1 is the maximum.
  - cnt never underflows.
- Invariants:
  - grant and done are each one-hot or zero.
  - done implies the same bit of grant.
  - busy equals (grant != 0).

Decomposition:
- Package delay_sched_pkg:
  - state enum sched_state_t {IDLE, COUNT, DONE}.
  - Default parameter constants.
- Sub-module rr_pick #(N): purely combinational round-robin picker.
  - Inputs: req[N], last index.
  - Outputs: onehot[N], index, valid.
- Counter and FSM stay inline in delay_sched.

Test Plan:
1. Reset: hold nrst=0 with req=4'b1111 -> grant=0, done=0, cnt=0, busy=0. Assert nrst=0 asynchronously mid-COUNT -> all outputs 0 immediately, no done.
2. Single request: req[0]=1, delay[0]=3 sampled at cycle 0 -> grant=0001 at cycle 1, cnt 3,2,1,0 over cycles 1-4, done=0001 at cycle 5 only, grant=0 at cycle 6.
3. Zero delay: req[2]=1, delay[2]=0 -> grant=0100 at cycle 1, done=0100 at cycle 2, busy low at cycle 3.
4. Round-robin fairness: req=1111 held, all delays=1 -> grant order 0,1,2,3,0. Each job is 4 cycles with one IDLE gap; done pulses appear in the same order.
5. Abort: req[1]=1, delay=5; drop req[1] when cnt=2 -> next cycle state IDLE, grant=0, no done[1]. With req[3] pending, requester 3 is granted on the following edge.
6. Late delay change and maximum value: delay[0]=7 loaded, then changed to 1 in COUNT -> done still on cycle 8 after grant; cnt never wraps below 0.
